// File: rtl/idif_8pt.sv
// idif_8pt: 8-point radix-2 DIF inverse FFT with 1/8 scaling; one registered output sample per cycle.
// Optional macro IDIF_SAT_EN: saturate the final result instead of wrapping to DW bits.

module idif_8pt #(
  parameter int DW   = 8,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] xr0,
  input  logic signed [DW-1:0] xr1,
  input  logic signed [DW-1:0] xr2,
  input  logic signed [DW-1:0] xr3,
  input  logic signed [DW-1:0] xr4,
  input  logic signed [DW-1:0] xr5,
  input  logic signed [DW-1:0] xr6,
  input  logic signed [DW-1:0] xr7,
  input  logic signed [DW-1:0] xi0,
  input  logic signed [DW-1:0] xi1,
  input  logic signed [DW-1:0] xi2,
  input  logic signed [DW-1:0] xi3,
  input  logic signed [DW-1:0] xi4,
  input  logic signed [DW-1:0] xi5,
  input  logic signed [DW-1:0] xi6,
  input  logic signed [DW-1:0] xi7,
  input  logic [2:0]           sel,
  output logic signed [DW-1:0] yr,
  output logic signed [DW-1:0] yi
);

  // 8x butterfly growth plus the ~1.41 twiddle gain, with a guard bit
  localparam int IW   = DW + FRAC + 5;
  localparam int PW   = IW + FRAC + 1;
  localparam int C_TW = $rtoi(0.70711 * (2.0 ** FRAC) + 0.5);
  localparam logic signed [PW-1:0] C_P = PW'(C_TW);
  localparam logic signed [IW-1:0] RND = IW'(2 ** (FRAC + 2));

  function automatic logic signed [IW-1:0] mulc(input logic signed [IW-1:0] v);
    logic signed [PW-1:0] p;
    p = PW'(v) * C_P;
    return IW'(p >>> FRAC);
  endfunction

  logic signed [DW-1:0] w_inr [8];
  logic signed [DW-1:0] w_ini [8];
  logic signed [IW-1:0] w_xr  [8];
  logic signed [IW-1:0] w_xi  [8];
  logic signed [IW-1:0] w_p1r [8];
  logic signed [IW-1:0] w_p1i [8];
  logic signed [IW-1:0] w_s2r [8];
  logic signed [IW-1:0] w_s2i [8];
  logic signed [IW-1:0] w_s3r [8];
  logic signed [IW-1:0] w_s3i [8];
  logic [2:0]           w_idx;
  logic signed [IW-1:0] w_rndr;
  logic signed [IW-1:0] w_rndi;
  logic signed [DW-1:0] w_yr;
  logic signed [DW-1:0] w_yi;

  assign w_inr = '{xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7};
  assign w_ini = '{xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7};

  always_comb begin : extend
    for (int k = 0; k < 8; k++) begin
      w_xr[k] = IW'(w_inr[k]) <<< FRAC;
      w_xi[k] = IW'(w_ini[k]) <<< FRAC;
    end
  end

  // Stage 1: sums in slots 0..3, twiddled differences in slots 4..7
  always_comb begin : stage1
    logic signed [IW-1:0] dr [4];
    logic signed [IW-1:0] di [4];
    for (int n = 0; n < 4; n++) begin
      w_p1r[n] = w_xr[n] + w_xr[n+4];
      w_p1i[n] = w_xi[n] + w_xi[n+4];
      dr[n]    = w_xr[n] - w_xr[n+4];
      di[n]    = w_xi[n] - w_xi[n+4];
    end
    w_p1r[4] = dr[0];
    w_p1i[4] = di[0];
    w_p1r[5] = mulc(dr[1] - di[1]);
    w_p1i[5] = mulc(dr[1] + di[1]);
    w_p1r[6] = -di[2];
    w_p1i[6] = dr[2];
    w_p1r[7] = mulc(-(dr[3] + di[3]));
    w_p1i[7] = mulc(dr[3] - di[3]);
  end

  always_comb begin : stage2
    logic signed [IW-1:0] tr, ti;
    // NOTE: every variable gets a value before any branch or loop so no latch can be inferred.
    tr = '0;
    ti = '0;
    for (int g = 0; g < 8; g += 4) begin
      w_s2r[g]   = w_p1r[g]   + w_p1r[g+2];
      w_s2i[g]   = w_p1i[g]   + w_p1i[g+2];
      w_s2r[g+1] = w_p1r[g+1] + w_p1r[g+3];
      w_s2i[g+1] = w_p1i[g+1] + w_p1i[g+3];
      w_s2r[g+2] = w_p1r[g]   - w_p1r[g+2];
      w_s2i[g+2] = w_p1i[g]   - w_p1i[g+2];
      tr         = w_p1r[g+1] - w_p1r[g+3];
      ti         = w_p1i[g+1] - w_p1i[g+3];
      w_s2r[g+3] = -ti;
      w_s2i[g+3] = tr;
    end
  end

  always_comb begin : stage3
    for (int m = 0; m < 4; m++) begin
      w_s3r[2*m]   = w_s2r[2*m] + w_s2r[2*m+1];
      w_s3i[2*m]   = w_s2i[2*m] + w_s2i[2*m+1];
      w_s3r[2*m+1] = w_s2r[2*m] - w_s2r[2*m+1];
      w_s3i[2*m+1] = w_s2i[2*m] - w_s2i[2*m+1];
    end
  end

  // Slot i of stage 3 holds x[bitrev(i)], so reversing sel picks natural order
  assign w_idx  = {sel[0], sel[1], sel[2]};
  assign w_rndr = (w_s3r[w_idx] + RND) >>> (FRAC + 3);
  assign w_rndi = (w_s3i[w_idx] + RND) >>> (FRAC + 3);

`ifdef IDIF_SAT_EN
  localparam logic signed [IW-1:0] SAT_MAX = IW'(2 ** (DW - 1) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = -IW'(2 ** (DW - 1));

  function automatic logic signed [DW-1:0] clamp(input logic signed [IW-1:0] v);
    if (v > SAT_MAX)      return DW'(SAT_MAX);
    else if (v < SAT_MIN) return DW'(SAT_MIN);
    else                  return v[DW-1:0];
  endfunction

  assign w_yr = clamp(w_rndr);
  assign w_yi = clamp(w_rndi);
`else
  logic w_unused_hi;
  assign w_yr        = w_rndr[DW-1:0];
  assign w_yi        = w_rndi[DW-1:0];
  assign w_unused_hi = ^{w_rndr[IW-1:DW], w_rndi[IW-1:DW]};
`endif

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      yr <= '0;
      yi <= '0;
    end else begin
      yr <= w_yr;
      yi <= w_yi;
    end
  end

endmodule

// File: tb/tb_idif_8pt.sv
// Scoreboard bench for idif_8pt: directed vectors with constant expectations plus
// randomized frames checked against a fixed-point DIF reference model.

module tb_idif_8pt;

  localparam int DW   = 8;
  localparam int FRAC = 8;
  localparam int C_TW = $rtoi(0.70711 * (2.0 ** FRAC) + 0.5);
  localparam int VMAX = (1 << (DW - 1)) - 1;
  localparam int VMIN = -(1 << (DW - 1));

  logic                 clk;
  logic                 rst;
  logic [2:0]           sel;
  logic signed [DW-1:0] xr [8];
  logic signed [DW-1:0] xi [8];
  logic signed [DW-1:0] yr;
  logic signed [DW-1:0] yi;

  typedef struct {
    string name;
    int    er;
    int    ei;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int p_r [8];
  int p_i [8];
  int o_r [8];
  int o_i [8];

  int exp_ramp [8] = '{1, 0, 2, 0, 3, 0, 4, 0};
  int exp_twid [8] = '{1, 1, -1, -1, -1, 1, 1, -1};
  int exp_pair [8] = '{2, 0, 2, 0, 2, 0, 2, 0};

  idif_8pt #(.DW(DW), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .xr0 (xr[0]), .xr1 (xr[1]), .xr2 (xr[2]), .xr3 (xr[3]),
    .xr4 (xr[4]), .xr5 (xr[5]), .xr6 (xr[6]), .xr7 (xr[7]),
    .xi0 (xi[0]), .xi1 (xi[1]), .xi2 (xi[2]), .xi3 (xi[3]),
    .xi4 (xi[4]), .xi5 (xi[5]), .xi6 (xi[6]), .xi7 (xi[7]),
    .sel (sel),
    .yr  (yr),
    .yi  (yi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [DW-1:0] ar, input logic signed [DW-1:0] ai,
                       input logic signed [DW-1:0] er, input logic signed [DW-1:0] ei);
    total++;
    if (ar !== er || ai !== ei) begin
      bad++;
      $display("FAIL %s: got yr=%0d yi=%0d, expected yr=%0d yi=%0d", name, ar, ai, er, ei);
    end
  endtask

  // Reference: textbook iterative radix-2 DIF over the spec's fixed-point rules
  function automatic int mulc(input int v);
    longint p;
    p = longint'(v) * longint'(C_TW);
    return int'(p >>> FRAC);
  endfunction

  function automatic int fit(input int v);
`ifdef IDIF_SAT_EN
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
`else
    int w;
    w = v & ((1 << DW) - 1);
    if (w > VMAX) w = w - (1 << DW);
    return w;
`endif
  endfunction

  task automatic run_model();
    int vr [8];
    int vi [8];
    for (int k = 0; k < 8; k++) begin
      vr[k] = p_r[k] * (1 << FRAC);
      vi[k] = p_i[k] * (1 << FRAC);
    end
    for (int span = 4; span >= 1; span = span / 2) begin
      for (int s = 0; s < 8; s += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int a, b, dr, di, e;
          a  = s + j;
          b  = a + span;
          dr = vr[a] - vr[b];
          di = vi[a] - vi[b];
          vr[a] = vr[a] + vr[b];
          vi[a] = vi[a] + vi[b];
          e = j * (4 / span);
          case (e)
            0:       begin vr[b] = dr;                vi[b] = di;          end
            1:       begin vr[b] = mulc(dr - di);     vi[b] = mulc(dr + di); end
            2:       begin vr[b] = -di;               vi[b] = dr;          end
            default: begin vr[b] = mulc(-(dr + di));  vi[b] = mulc(dr - di); end
          endcase
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      int n;
      n = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
      o_r[n] = fit((vr[i] + (1 << (FRAC + 2))) >>> (FRAC + 3));
      o_i[n] = fit((vi[i] + (1 << (FRAC + 2))) >>> (FRAC + 3));
    end
  endtask

  task automatic push_exp(input string name, input int er, input int ei);
    exp_t e;
    e.name = name;
    e.er   = er;
    e.ei   = ei;
    sb.push_back(e);
  endtask

  task automatic drive(input bit r, input int s);
    @(negedge clk);
    rst = r;
    sel = 3'(s);
    for (int k = 0; k < 8; k++) begin
      xr[k] = DW'(p_r[k]);
      xi[k] = DW'(p_i[k]);
    end
  endtask

  task automatic step_const(input string name, input bit r, input int s, input int er, input int ei);
    drive(r, s);
    push_exp(name, er, ei);
  endtask

  task automatic step_model(input string name, input bit r, input int s);
    drive(r, s);
    if (r) begin
      push_exp(name, 0, 0);
    end else begin
      run_model();
      push_exp(name, o_r[s], o_i[s]);
    end
  endtask

  // Monitor: one registered result per edge, compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, yr, yi, DW'(e.er), DW'(e.ei));
      end
    end
  end

  initial begin
    rst = 1'b1;
    sel = '0;
    for (int k = 0; k < 8; k++) begin
      xr[k] = '0; xi[k] = '0; p_r[k] = 0; p_i[k] = 0;
    end
    repeat (2) @(posedge clk);

    p_r = '{10, -2, -2, -2, 10, -2, -2, -2};
    p_i = '{0, 2, 0, -2, 0, 2, 0, -2};
    for (int s = 0; s < 8; s++) step_const("rst_hold", 1'b1, s, 0, 0);
    for (int s = 0; s < 8; s++) step_const("ramp", 1'b0, s, exp_ramp[s], 0);

    p_r = '{8, 0, 0, 0, 0, 0, 0, 0};
    p_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int s = 0; s < 8; s++) step_const("dc_impulse", 1'b0, s, 1, 0);

    p_r = '{0, 2, 0, 2, 0, 2, 0, 2};
    p_i = '{0, 2, -4, -2, 0, 2, 4, -2};
    for (int s = 0; s < 8; s++) step_const("twiddle", 1'b0, s, exp_twid[s], 0);

    p_r = '{8, 0, 0, 0, 8, 0, 0, 0};
    p_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int s = 0; s < 8; s++) step_const("pair", 1'b0, s, exp_pair[s], 0);

    p_r = '{0, 0, 0, 0, 0, 0, 0, 0};
    p_i = '{8, 8, 8, 8, 8, 8, 8, 8};
    for (int s = 0; s < 8; s++) step_const("imag", 1'b0, s, 0, (s == 0) ? 8 : 0);

    p_r = '{10, -2, -2, -2, 10, -2, -2, -2};
    p_i = '{0, 2, 0, -2, 0, 2, 0, -2};
    for (int s = 0; s < 3; s++) step_const("pre_rst", 1'b0, s, exp_ramp[s], 0);
    step_const("mid_rst", 1'b1, 3, 0, 0);
    step_const("post_rst", 1'b0, 4, 3, 0);
    step_const("post_rst", 1'b0, 6, 4, 0);

    p_r = '{VMAX, VMAX, VMAX, VMAX, VMAX, VMAX, VMAX, VMAX};
    p_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    step_const("all_max_re", 1'b0, 0, VMAX, 0);
    step_const("all_max_re", 1'b0, 5, 0, 0);
    p_i = '{VMAX, VMAX, VMAX, VMAX, VMAX, VMAX, VMAX, VMAX};
    step_const("all_max_cx", 1'b0, 0, VMAX, VMAX);
    step_const("all_max_cx", 1'b0, 3, 0, 0);

    // Phases aligned so x[1] exceeds the output range (sat vs wrap)
    p_r = '{VMAX, VMAX, 0, -VMAX, -VMAX, -VMAX, 0, VMAX};
    p_i = '{0, -VMAX, -VMAX, -VMAX, 0, VMAX, VMAX, VMAX};
    for (int s = 0; s < 8; s++) step_model("overflow", 1'b0, s);

    for (int it = 0; it < 400; it++) begin
      bit corner;
      corner = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 8; k++) begin
        if (corner) begin
          p_r[k] = ($urandom_range(0, 1) == 1) ? VMAX : VMIN;
          p_i[k] = ($urandom_range(0, 1) == 1) ? VMAX : VMIN;
        end else begin
          p_r[k] = int'($urandom_range(0, (1 << DW) - 1)) + VMIN;
          p_i[k] = int'($urandom_range(0, (1 << DW) - 1)) + VMIN;
        end
      end
      step_model("random", ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)));
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
